// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings for the multi-cycle control path
package rv_ctrl_pkg;

    typedef enum logic [4:0] {
        OP_LW      = 5'd0,
        OP_SW      = 5'd1,
        OP_JAL     = 5'd2,
        OP_ADDI    = 5'd3,
        OP_ADD     = 5'd4,
        OP_SUB     = 5'd5,
        OP_MUL     = 5'd6,
        OP_MULH    = 5'd7,
        OP_BGE     = 5'd8,
        OP_XOR     = 5'd9,
        OP_AND     = 5'd10,
        OP_OR      = 5'd11,
        OP_LUI     = 5'd12,
        OP_AUIPC   = 5'd13,
        OP_BLT     = 5'd14,
        OP_BEQ     = 5'd15,
        OP_BNE     = 5'd16,
        OP_ILLEGAL = 5'd31
    } op_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_XOR    = 4'd2,
        ALU_AND    = 4'd3,
        ALU_OR     = 4'd4,
        ALU_PASS_B = 4'd5,
        ALU_CMP_EQ = 4'd6,
        ALU_CMP_LT = 4'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_MUL_WAIT = 3'd4,
        S_WB       = 3'd5,
        S_TRAP     = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_OFFSET = 2'd1,
        PC_ALU    = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_MUL = 2'd3
    } wb_sel_t;

    typedef struct packed {
        logic    ir_we;
        logic    pc_we;
        pc_src_t pc_src;
        logic    mem_req;
        logic    mem_we;
        logic    mem_addr_sel;
        logic    alu_src_a;
        logic    alu_src_b;
        alu_op_t alu_op;
        logic    mul_start;
        logic    mul_high;
        logic    reg_we;
        wb_sel_t wb_sel;
        logic    retire;
    } ctrl_word_t;

    // Every code past BNE, including the explicit ILLEGAL, is unimplemented.
    function automatic logic op_is_legal(logic [4:0] op);
        return op <= 5'd16;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - unified memory port request/ready handshake
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/ctrl_decode_rom.sv
// rtl/ctrl_decode_rom.sv - control word for each (state, captured op) pair
module ctrl_decode_rom
    import rv_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [4:0] op_i,
    input  logic       mem_ready_i,
    input  logic       branch_cond_i,
    output ctrl_word_t word_o
);
    logic    is_branch;
    logic    is_mul;
    logic    is_mulh;
    logic    alu_a;
    logic    alu_b;
    alu_op_t alu_fn;

    always_comb begin
        is_branch = (op_i == OP_BEQ) || (op_i == OP_BNE) || (op_i == OP_BLT) || (op_i == OP_BGE);
        is_mulh   = (op_i == OP_MULH);
        is_mul    = (op_i == OP_MUL) || is_mulh;
        alu_a     = 1'b0;
        alu_b     = 1'b0;
        alu_fn    = ALU_ADD;
        case (op_i)
            OP_ADDI, OP_LW, OP_SW: alu_b = 1'b1;
            OP_AUIPC, OP_JAL: begin
                alu_a = 1'b1;
                alu_b = 1'b1;
            end
            OP_LUI: begin
                alu_b  = 1'b1;
                alu_fn = ALU_PASS_B;
            end
            OP_SUB:         alu_fn = ALU_SUB;
            OP_XOR:         alu_fn = ALU_XOR;
            OP_AND:         alu_fn = ALU_AND;
            OP_OR:          alu_fn = ALU_OR;
            OP_BEQ, OP_BNE: alu_fn = ALU_CMP_EQ;
            OP_BLT, OP_BGE: alu_fn = ALU_CMP_LT;
            default: ;
        endcase
    end

    // ALU selects stay applied through MEM and WB so the datapath result is stable there.
    always_comb begin
        word_o = '0;
        case (state_i)
            S_FETCH: begin
                word_o.mem_req = 1'b1;
                word_o.ir_we   = mem_ready_i;
                word_o.pc_we   = mem_ready_i;
                word_o.pc_src  = PC_PLUS4;
            end
            S_EXEC: begin
                word_o.alu_src_a = alu_a;
                word_o.alu_src_b = alu_b;
                word_o.alu_op    = alu_fn;
                if (is_branch) begin
                    word_o.pc_we  = branch_cond_i;
                    word_o.pc_src = PC_OFFSET;
                    word_o.retire = 1'b1;
                end else if (op_i == OP_JAL) begin
                    word_o.pc_we  = 1'b1;
                    word_o.pc_src = PC_OFFSET;
                    word_o.reg_we = 1'b1;
                    word_o.wb_sel = WB_PC4;
                    word_o.retire = 1'b1;
                end else if (is_mul) begin
                    word_o.mul_start = 1'b1;
                    word_o.mul_high  = is_mulh;
                end
            end
            S_MEM: begin
                word_o.alu_src_a    = alu_a;
                word_o.alu_src_b    = alu_b;
                word_o.alu_op       = alu_fn;
                word_o.mem_req      = 1'b1;
                word_o.mem_addr_sel = 1'b1;
                word_o.mem_we       = (op_i == OP_SW);
                word_o.retire       = mem_ready_i && (op_i == OP_SW);
            end
            S_MUL_WAIT: word_o.mul_high = is_mulh;
            S_WB: begin
                word_o.alu_src_a = alu_a;
                word_o.alu_src_b = alu_b;
                word_o.alu_op    = alu_fn;
                word_o.reg_we    = 1'b1;
                word_o.retire    = 1'b1;
                word_o.wb_sel    = (op_i == OP_LW) ? WB_MEM : (is_mul ? WB_MUL : WB_ALU);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle sequencer for the RV32IM core
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_ctrl_if.master        mem,
    input  logic [4:0]               op_type,
    input  logic                     branch_cond,
    input  logic                     mul_done,
    output logic                     ir_we,
    output logic                     pc_we,
    output logic [1:0]               pc_src,
    output logic                     alu_src_a,
    output logic                     alu_src_b,
    output logic [3:0]               alu_op,
    output logic                     mul_start,
    output logic                     mul_high,
    output logic                     reg_we,
    output logic [1:0]               wb_sel,
    output logic                     retire,
    output logic                     trap,
    output logic [2:0]               state
);
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t        state_q, state_d;
    logic [4:0]    op_q;
    logic          idle_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;
    logic          timeout;
    ctrl_word_t    rom_word;
    ctrl_word_t    word;

    ctrl_decode_rom u_rom (
        .state_i       (state_q),
        .op_i          (op_q),
        .mem_ready_i   (mem.mem_ready),
        .branch_cond_i (branch_cond),
        .word_o        (rom_word)
    );

    // idle_q holds the first cycle after reset quiet so the memory side can drop a stale request.
    always_comb begin
        if (idle_q) begin
            word = '0;
        end else begin
            word = rom_word;
        end
        waiting = word.mem_req && !mem.mem_ready;
        timeout = (MEM_TIMEOUT != 0) && waiting && (cnt_q == CW'(MEM_TIMEOUT - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = waiting ? cnt_q + CW'(1) : '0;
        case (state_q)
            S_FETCH: begin
                if (!idle_q) begin
                    if (mem.mem_ready) begin
                        state_d = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_TRAP;
                    end
                end
            end
            S_DECODE: state_d = op_is_legal(op_type) ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (op_q)
                    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JAL: state_d = S_FETCH;
                    OP_MUL, OP_MULH:                        state_d = S_MUL_WAIT;
                    OP_LW, OP_SW:                           state_d = S_MEM;
                    default:                                state_d = S_WB;
                endcase
            end
            S_MUL_WAIT: if (mul_done) state_d = S_WB;
            S_MEM: begin
                if (mem.mem_ready) begin
                    state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= 1'b0;
            if (state_q == S_DECODE) begin
                op_q <= op_type;
            end
        end
    end

    assign mem.mem_req      = word.mem_req;
    assign mem.mem_we       = word.mem_we;
    assign mem.mem_addr_sel = word.mem_addr_sel;
    assign ir_we            = word.ir_we;
    assign pc_we            = word.pc_we;
    assign pc_src           = word.pc_src;
    assign alu_src_a        = word.alu_src_a;
    assign alu_src_b        = word.alu_src_b;
    assign alu_op           = word.alu_op;
    assign mul_start        = word.mul_start;
    assign mul_high         = word.mul_high;
    assign reg_we           = word.reg_we;
    assign wb_sel           = word.wb_sel;
    assign retire           = word.retire;
    assign trap             = (state_q == S_TRAP);
    assign state            = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - instruction-level trace checks for multicycle_ctrl
module tb_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] op_type;
    logic       branch_cond, mul_done;
    logic       ir_we, pc_we, alu_src_a, alu_src_b, mul_start, mul_high, reg_we, retire, trap;
    logic [1:0] pc_src, wb_sel;
    logic [3:0] alu_op;
    logic [2:0] state;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem(mif), .op_type(op_type),
        .branch_cond(branch_cond), .mul_done(mul_done),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mul_start(mul_start), .mul_high(mul_high), .reg_we(reg_we),
        .wb_sel(wb_sel), .retire(retire), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req, mem_we, addr_sel, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       retire, mul_start, mul_high, trap;
    } out_t;

    typedef struct {
        logic       mr, bc, md, dec, chk_alu;
        logic [5:0] alu;
        out_t       e;
    } cyc_t;

    typedef struct {
        logic [4:0] op;
        int         fw, mw, ml;
        logic       cond;
        int         cyc;
    } vec_t;

    cyc_t       tr[$];
    vec_t       vt[$];
    logic [4:0] cur_op;
    bit         trapped;
    int         checks = 0;
    int         failures = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t o_st(logic [2:0] s);
        out_t o = '0;
        o.st = s;
        return o;
    endfunction

    // {alu_src_a, alu_src_b, alu_op} the spec dictates for the ops it lists
    function automatic logic [5:0] alu_exp(logic [4:0] op);
        case (op)
            OP_ADDI, OP_LW, OP_SW: return {1'b0, 1'b1, 4'd0};
            OP_AUIPC:              return {1'b1, 1'b1, 4'd0};
            OP_LUI:                return {1'b0, 1'b1, 4'd5};
            OP_SUB:                return {1'b0, 1'b0, 4'd1};
            OP_XOR:                return {1'b0, 1'b0, 4'd2};
            OP_AND:                return {1'b0, 1'b0, 4'd3};
            OP_OR:                 return {1'b0, 1'b0, 4'd4};
            default:               return {1'b0, 1'b0, 4'd0};
        endcase
    endfunction

    function automatic logic alu_checked(logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_ADDI, OP_LW, OP_SW, OP_AUIPC, OP_LUI};
    endfunction

    task automatic push(input logic mr, input logic bc, input logic md, input out_t e,
                        input logic dec, input logic ca, input logic [5:0] alu);
        cyc_t c;
        c.mr = mr; c.bc = bc; c.md = md; c.e = e; c.dec = dec; c.chk_alu = ca; c.alu = alu;
        tr.push_back(c);
    endtask

    task automatic add_trap();
        out_t o;
        for (int i = 0; i < 3; i++) begin
            o = o_st(S_TRAP);
            o.trap = 1'b1;
            push(rb(), rb(), rb(), o, 1'b0, 1'b0, 6'd0);
        end
        trapped = 1'b1;
    endtask

    // Expected per-cycle trace of one instruction, from the phase rules.
    task automatic build(input logic [4:0] op, input int fw, input int mw, input int ml, input logic cond);
        out_t o;
        bit   is_br, is_mul, is_mem;
        int   n;
        cur_op  = op;
        trapped = 1'b0;
        is_br   = op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE};
        is_mul  = op inside {OP_MUL, OP_MULH};
        is_mem  = op inside {OP_LW, OP_SW};
        n = (fw < TO) ? fw : TO;
        for (int i = 0; i < n; i++) begin
            o = o_st(S_FETCH); o.mem_req = 1'b1;
            push(1'b0, rb(), rb(), o, 1'b0, 1'b0, 6'd0);
        end
        if (fw >= TO) begin add_trap(); return; end
        o = o_st(S_FETCH); o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
        push(1'b1, rb(), rb(), o, 1'b0, 1'b0, 6'd0);
        push(rb(), rb(), rb(), o_st(S_DECODE), 1'b1, 1'b0, 6'd0);
        if (op > 5'd16) begin add_trap(); return; end
        o = o_st(S_EXEC);
        if (is_br) begin
            o.pc_we = cond; o.pc_src = 2'd1; o.retire = 1'b1;
            push(rb(), cond, rb(), o, 1'b0, 1'b0, 6'd0);
            return;
        end
        if (op == OP_JAL) begin
            o.pc_we = 1'b1; o.pc_src = 2'd1; o.reg_we = 1'b1; o.wb_sel = 2'd2; o.retire = 1'b1;
            push(rb(), rb(), rb(), o, 1'b0, 1'b0, 6'd0);
            return;
        end
        if (is_mul) begin
            o.mul_start = 1'b1; o.mul_high = (op == OP_MULH);
        end
        push(rb(), rb(), rb(), o, 1'b0, alu_checked(op), alu_exp(op));
        if (is_mul) begin
            for (int i = 0; i < ml; i++) begin
                o = o_st(S_MUL_WAIT); o.mul_high = (op == OP_MULH);
                push(rb(), rb(), (i == ml - 1), o, 1'b0, 1'b0, 6'd0);
            end
        end
        if (is_mem) begin
            n = (mw < TO) ? mw : TO;
            for (int i = 0; i <= n; i++) begin
                o = o_st(S_MEM); o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = (op == OP_SW);
                if (i == n && mw < TO) o.retire = (op == OP_SW);
                if (i < n || mw < TO) push((i == n), rb(), rb(), o, 1'b0, 1'b0, 6'd0);
            end
            if (mw >= TO) begin add_trap(); return; end
            if (op == OP_SW) return;
        end
        o = o_st(S_WB); o.reg_we = 1'b1; o.retire = 1'b1;
        o.wb_sel = (op == OP_LW) ? 2'd1 : (is_mul ? 2'd3 : 2'd0);
        push(rb(), rb(), rb(), o, 1'b0, 1'b0, 6'd0);
    endtask

    function automatic out_t observe();
        out_t o;
        o.st = state; o.mem_req = mif.mem_req; o.mem_we = mif.mem_we; o.addr_sel = mif.mem_addr_sel;
        o.ir_we = ir_we; o.pc_we = pc_we; o.pc_src = pc_src; o.reg_we = reg_we; o.wb_sel = wb_sel;
        o.retire = retire; o.mul_start = mul_start; o.mul_high = mul_high; o.trap = trap;
        return o;
    endfunction

    task automatic check_out(input string name, input out_t want);
        out_t got;
        got = observe();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s t=%0t op=%0d got=%05h want=%05h (state got=%0d want=%0d)",
                     name, $time, cur_op, got, want, got.st, want.st);
        end
    endtask

    task automatic run_trace(input int limit, output int ret_at, output int nret);
        cyc_t c;
        int   idx;
        idx = 0; ret_at = 0; nret = 0;
        while (tr.size() > 0 && (limit < 0 || idx < limit)) begin
            c = tr.pop_front();
            @(negedge clk);
            mif.mem_ready = c.mr;
            branch_cond   = c.bc;
            mul_done      = c.md;
            op_type       = c.dec ? cur_op : 5'($urandom_range(0, 31));
            #1;
            check_out("trace", c.e);
            if (c.chk_alu) begin
                checks++;
                if ({alu_src_a, alu_src_b, alu_op} !== c.alu) begin
                    failures++;
                    $display("FAIL alu_sel op=%0d got=%02h want=%02h", cur_op, {alu_src_a, alu_src_b, alu_op}, c.alu);
                end
            end
            if (retire === 1'b1) begin
                nret++;
                if (ret_at == 0) ret_at = idx + 1;
            end
            idx++;
        end
        tr.delete();
    endtask

    task automatic do_reset(input logic mr0);
        @(negedge clk);
        rst = 1'b1; mif.mem_ready = mr0; mul_done = 1'b1;
        @(negedge clk);
        mif.mem_ready = 1'b1;
        #1;
        check_out("after_reset", o_st(S_FETCH));
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ra, nr;
        mif.mem_ready = 1'b0; branch_cond = 1'b0; mul_done = 1'b0; op_type = '0;
        do_reset(1'b0);

        vt.push_back('{OP_ADD,     0, 0, 0, 1'b0, 4});
        vt.push_back('{OP_LW,      0, 3, 0, 1'b0, 8});
        vt.push_back('{OP_BEQ,     0, 0, 0, 1'b1, 3});
        vt.push_back('{OP_BNE,     0, 0, 0, 1'b0, 3});
        vt.push_back('{OP_MUL,     0, 0, 5, 1'b0, 9});
        vt.push_back('{OP_MULH,    1, 0, 2, 1'b0, 7});
        vt.push_back('{OP_SW,      0, 0, 0, 1'b0, 4});
        vt.push_back('{OP_SW,      0, 3, 0, 1'b0, 7});
        vt.push_back('{OP_LW,      0, 0, 0, 1'b0, 5});
        vt.push_back('{OP_JAL,     0, 0, 0, 1'b0, 3});
        vt.push_back('{OP_LUI,     2, 0, 0, 1'b0, 6});
        vt.push_back('{OP_AUIPC,   0, 0, 0, 1'b0, 4});
        vt.push_back('{OP_ADDI,    3, 0, 0, 1'b0, 7});
        vt.push_back('{OP_BLT,     1, 0, 0, 1'b1, 4});
        vt.push_back('{OP_BGE,     0, 0, 0, 1'b0, 3});
        vt.push_back('{OP_SUB,     0, 0, 0, 1'b0, 4});
        vt.push_back('{OP_XOR,     0, 0, 0, 1'b0, 4});
        vt.push_back('{OP_AND,     0, 0, 0, 1'b0, 4});
        vt.push_back('{OP_OR,      0, 0, 0, 1'b0, 4});
        vt.push_back('{OP_ILLEGAL, 0, 0, 0, 1'b0, 0});
        vt.push_back('{5'd20,      0, 0, 0, 1'b0, 0});
        vt.push_back('{OP_ADD,     4, 0, 0, 1'b0, 0});
        vt.push_back('{OP_SW,      0, 4, 0, 1'b0, 0});

        foreach (vt[i]) begin
            build(vt[i].op, vt[i].fw, vt[i].mw, vt[i].ml, vt[i].cond);
            run_trace(-1, ra, nr);
            checks++;
            if (vt[i].cyc != 0) begin
                if (ra != vt[i].cyc || nr != 1) begin
                    failures++;
                    $display("FAIL latency vec=%0d op=%0d got_cycles=%0d retires=%0d want_cycles=%0d",
                             i, vt[i].op, ra, nr, vt[i].cyc);
                end
            end else if (nr != 0 || trap !== 1'b1) begin
                failures++;
                $display("FAIL trap_entry vec=%0d op=%0d got_trap=%b retires=%0d want_trap=1 retires=0",
                         i, vt[i].op, trap, nr);
            end
            if (trapped) do_reset(rb());
        end

        // Reset in the middle of a store's data handshake.
        build(OP_SW, 0, 3, 0, 1'b0);
        run_trace(4, ra, nr);
        do_reset(1'b0);
        build(OP_ADD, 0, 0, 0, 1'b0);
        run_trace(-1, ra, nr);
        checks++;
        if (ra != 4 || nr != 1) begin
            failures++;
            $display("FAIL recover_after_reset got_cycles=%0d retires=%0d want_cycles=4", ra, nr);
        end

        for (int k = 0; k < 150; k++) begin
            logic [4:0] op;
            int         fw, mw, ml;
            op = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            fw = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 3));
            ml = int'($urandom_range(1, 6));
            build(op, fw, mw, ml, rb());
            run_trace(-1, ra, nr);
            if (trapped) do_reset(rb());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32IM core.
- Sequences fetch, decode, execute, memory and write-back around the existing instruction decoder, register file, ALU, multiplier and unified memory port.
- Takes the decoder's op_type plus status handshakes and drives every datapath enable and mux select.
- One instruction in flight; no pipelining.

Parameters:
- MEM_TIMEOUT, 255, max cycles to wait on mem_ready before entering TRAP (0 disables the timeout).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- op_type  in  5  decoded instruction class from decoder
- branch_cond  in  1  ALU compare result for the current branch op
- mem_ready  in  1  memory completes the outstanding request this cycle
- mul_done  in  1  multiplier result valid (single-cycle pulse)
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_src  out  2  0=PC+4, 1=PC+offset, 2=ALU result
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a store
- mem_addr_sel  out  1  0=PC (fetch), 1=ALU result (data)
- alu_src_a  out  1  0=rs1, 1=PC
- alu_src_b  out  1  0=rs2, 1=immediate
- alu_op  out  4  ALU function, package encoding
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_high  out  1  select upper product (MULH)
- reg_we  out  1  register-file write enable for rd
- wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4, 3=multiplier
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky: illegal op or memory timeout
- state  out  3  current FSM state, for debug

Behaviour:
- Reset: all outputs 0; state=FETCH; timeout counter 0; trap clears.
- Outputs are Moore, decoded from state and the registered op_type; mul_start and retire are the only pulses.

FETCH:
- mem_req=1, mem_we=0, mem_addr_sel=0.
- On mem_ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.

DECODE (1 cycle):
- op_type is captured into an internal register; the decoder is combinational on the IR.
- Illegal or unlisted code → TRAP; otherwise → EXEC.

EXEC (1 cycle):
- ALU selects come from the captured op:
  - R-type: a=rs1, b=rs2.
  - ADDI, LW, SW: a=rs1, b=imm.
  - AUIPC: a=PC, b=imm.
  - LUI: b=imm, alu_op=PASS_B.
- Branches (BEQ, BNE, BLT, BGE):
  - If branch_cond, assert pc_we with pc_src=1.
  - Assert retire; → FETCH.
- JAL: pc_we=1, pc_src=1, reg_we=1, wb_sel=2, retire=1; → FETCH.
- MUL/MULH: mul_start=1; → MUL_WAIT.
- LW/SW: → MEM.
- All other ops: → WB.

MUL_WAIT:
- Hold mul_high. On mul_done → WB with wb_sel=3.
- No timeout applies in this state.

MEM:
- mem_req=1, mem_addr_sel=1, mem_we=1 for SW.
- On mem_ready:
  - SW: retire; → FETCH.
  - LW: → WB with wb_sel=1.

WB (1 cycle):
- reg_we=1, retire=1; → FETCH.
- Writes to x0 are suppressed by the register file, not here.

TRAP:
- All enables 0; trap=1. Remains in TRAP until rst.

Memory handshake:
- mem_req stays high, with address and write select stable, until mem_ready is sampled high.
- mem_ready while mem_req=0 is ignored.
- The timeout counter increments each waiting cycle in FETCH or MEM and clears on mem_ready.
- Reaching MEM_TIMEOUT → TRAP.

Latencies with zero-wait memory:
- Branch/JAL: 3 cycles.
- ALU ops, SW: 4 cycles.
- LW: 5 cycles.
- MUL: 4 cycles + multiplier latency.

Boundary and corner cases:
- rst asserted in any state, including mid-handshake: next cycle is FETCH with mem_req=0 for one cycle. The memory side must drop any pending request.
- mem_ready and a timeout expiry in the same cycle: mem_ready wins.
- mul_done outside MUL_WAIT is ignored.

Decomposition:
- Package rv_ctrl_pkg holds:
  - op_type codes: LW=0, SW=1, JAL=2, ADDI=3, ADD=4, SUB=5, MUL=6, MULH=7, BGE=8, XOR=9, AND=10, OR=11, LUI=12, AUIPC=13, BLT=14, BEQ=15, BNE=16, ILLEGAL=31.
  - alu_op codes: ADD, SUB, XOR, AND, OR, PASS_B, CMP_EQ, CMP_LT.
  - State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, MUL_WAIT=4, WB=5, TRAP=7.
  - pc_src and wb_sel encodings.
- The decoder shares the op_type codes from this package.
- One sub-module, ctrl_decode_rom: combinational map from (state, op_type) to the control-word outputs.
- The FSM, timeout counter and handshakes remain in multicycle_ctrl.

Test Plan:
- ADD, zero-wait memory → ir_we at cycle 1, reg_we with wb_sel=0 at cycle 4, retire at cycle 4, next mem_req at cycle 5.
- LW, data mem_ready delayed 3 cycles → mem_req held 4 cycles with mem_addr_sel=1, then reg_we with wb_sel=1, retire; total 8 cycles.
- BEQ, branch_cond=1 then BNE, branch_cond=0 → first: pc_we with pc_src=1 in EXEC; second: no pc_we in EXEC; each retires in 3 cycles.
- MUL, mul_done after 5 cycles → mul_start pulse lasts 1 cycle, then WB with wb_sel=3; MULH additionally drives mul_high=1.
- op_type=31, then FETCH with mem_ready never asserted after MEM_TIMEOUT=4 → first: TRAP after DECODE; second: TRAP after 4 wait cycles; trap=1 and all enables 0 in both cases.
- rst raised during MEM of an SW → next cycle state=FETCH, mem_req=0, trap=0, no retire pulse.
